mac_accumulator: RTL

- Sequential stage directly downstream of the combinational 8x8 array multiplier.
- Consumes its 16-bit product stream under a valid/ready handshake and accumulates a dot-product over a frame of terms.
- Presents the sum, term count and a sticky overflow flag on a held output handshake.
- Turns the bare multiplier into a MAC datapath for the verification environment.

---
 rtl/mac_accumulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: frame-based unsigned accumulator that sits behind the 8x8
// array multiplier. Product beats arrive on a valid/ready handshake. A frame
// closes on in_last or when MAX_TERMS beats have been taken. The closed
// frame's sum, beat count and sticky overflow are then held on a second
// handshake until the consumer takes them.
module mac_accumulator #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  // Two-state frame controller. ACC takes beats; OUT holds the result.
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  // Beat count at which a frame is forced closed without in_last.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  logic [0:0]       state;
  logic [0:0]       state_nxt;

  // Running frame state. This is separate from the output registers so the
  // presented result stays frozen while the next frame fills.
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  // Post-update candidates for the beat being accepted this cycle.
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  logic             beat;   // product accepted this cycle
  logic             close;  // accepted beat ends the frame
  logic             drain;  // result taken by the consumer this cycle

  // Handshake flags are pure decodes of the state register. in_valid and
  // out_ready therefore have no combinational path to in_ready.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);

  assign beat  = in_valid && in_ready;
  assign drain = out_valid && out_ready;

  // Zero-extend the product and add with one extra bit. The extra bit is the
  // carry out of the accumulator MSB, which sets the sticky overflow.
  assign sum_ext = {1'b0, sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign sum_nxt = sum_ext[ACC_W-1:0];
  assign ovf_nxt = ovf | sum_ext[ACC_W];
  assign cnt_nxt = cnt + CNT_W'(1);

  // The frame closes on an explicit last beat or on the beat that reaches
  // the term limit. A zero-valued beat still counts toward that limit.
  assign close = beat && (in_last || (cnt_nxt == MAX_CNT));

  // Next-state selection for the frame controller.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (close) state_nxt = ST_OUT;
      ST_OUT:  if (drain) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  // State register. Reset drops any partial frame or pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // Running accumulator. It updates on each accepted beat and clears when the
  // result is consumed, so the next frame starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (drain) begin
      sum <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      sum <= sum_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  // Result registers. They capture the post-update totals on the closing
  // beat and keep them until the next frame closes, including after the
  // consumer has taken them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (close) begin
      out_acc <= sum_nxt;
      out_cnt <= cnt_nxt;
      out_ovf <= ovf_nxt;
    end
  end

  // Protocol sanity: a stalled result must not move, and the two handshakes
  // are mutually exclusive.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_acc) &&
                                   $stable(out_cnt) && $stable(out_ovf)));

  a_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready != out_valid);

endmodule
